// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants and encodings for the register file write scheduler.
// Optional feature macro: REGFILE_SCHED_RR_EN selects round-robin arbitration.
package regfile_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 32;
   localparam int CNT_W    = 16;

   // Scheduler FSM: clear sweep first, then normal writeback arbitration
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Writeback source identifiers (also the encoding of the RR pointer)
   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/regfile_write_scheduler_arb.sv
// Two-source writeback arbiter for the register file write port.
// REGFILE_SCHED_RR_EN: round-robin with a one-bit favour pointer;
// otherwise fixed priority s0 > s1 and no state at all.
module wb_arbiter2
   import regfile_pkg::*;
(
`ifdef REGFILE_SCHED_RR_EN
   input  logic clk_i,
   input  logic rst_i,
`endif
   input  logic en_i,
   input  logic req0_i,
   input  logic req1_i,
   output logic gnt0_o,
   output logic gnt1_o,
   output logic gnt_src_o
);

`ifdef REGFILE_SCHED_RR_EN
   logic ptr_q;
   logic ptr_d;
   logic fav1;

   // Grant the favoured source on contention; otherwise whoever asks
   always_comb begin
      fav1   = (ptr_q == SRC1);
      gnt0_o = en_i & req0_i & (~req1_i | ~fav1);
      gnt1_o = en_i & req1_i & (~req0_i |  fav1);
   end

   // Only a contended grant moves the pointer, toward the loser
   always_comb begin
      ptr_d = ptr_q;
      if (en_i && req0_i && req1_i)
         ptr_d = gnt0_o ? SRC1 : SRC0;
   end

   // Pointer register; reset favours s0
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= SRC0;
      else       ptr_q <= ptr_d;
   end
`else
   // Fixed priority: s0 always wins
   always_comb begin
      gnt0_o = en_i & req0_i;
      gnt1_o = en_i & req1_i & ~req0_i;
   end
`endif

   // Source index of the current grant, used for the write mux
   always_comb begin
      gnt_src_o = gnt1_o ? SRC1 : SRC0;
   end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register file write-port scheduler: clears r0..r31 after reset, then
// shares the single write port between s0 (ALU) and s1 (load/mul).
// Optional feature macro: REGFILE_SCHED_RR_EN (round-robin arbitration).
module regfile_write_scheduler
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = regfile_pkg::ADDR_W,
   parameter int DATA_W   = regfile_pkg::DATA_W,
   parameter int NUM_REGS = regfile_pkg::NUM_REGS,
   parameter int CNT_W    = regfile_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s0_valid,
   input  logic [ADDR_W-1:0] s0_rd,
   input  logic [DATA_W-1:0] s0_data,
   output logic              s0_ready,
   input  logic              s1_valid,
   input  logic [ADDR_W-1:0] s1_rd,
   input  logic [DATA_W-1:0] s1_data,
   output logic              s1_ready,
   output logic              regwr,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] data,
   output logic              init_done,
   output logic [CNT_W-1:0]  conflict_cnt
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_e            state_q;
   logic [ADDR_W-1:0] idx_q;
   logic              regwr_q;
   logic [ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0] data_q;
   logic              init_done_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;

   logic              run;
   logic              gnt0;
   logic              gnt1;
   logic              gnt_src;
   logic              hs;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;
   logic              sel_wr;

   // Requests are only arbitrated once the clear sweep is finished
   always_comb begin
      run = (state_q == ST_RUN);
   end

   wb_arbiter2 u_arb (
`ifdef REGFILE_SCHED_RR_EN
      .clk_i     (clk),
      .rst_i     (rst),
`endif
      .en_i      (run),
      .req0_i    (s0_valid),
      .req1_i    (s1_valid),
      .gnt0_o    (gnt0),
      .gnt1_o    (gnt1),
      .gnt_src_o (gnt_src)
   );

   // Select the granted request; r0 handshakes complete but never write
   always_comb begin
      hs       = gnt0 | gnt1;
      sel_rd   = (gnt_src == SRC1) ? s1_rd   : s0_rd;
      sel_data = (gnt_src == SRC1) ? s1_data : s0_data;
      sel_wr   = hs && (sel_rd != '0);
      s0_ready = gnt0;
      s1_ready = gnt1;
   end

   // FSM plus registered write port: sweep in INIT, accepted writes in RUN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         idx_q       <= '0;
         regwr_q     <= 1'b0;
         rd_q        <= '0;
         data_q      <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               regwr_q <= 1'b1;
               rd_q    <= idx_q;
               data_q  <= '0;
               idx_q   <= idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end
            end
            ST_RUN: begin
               regwr_q <= sel_wr;
               // Address/data hold unless a real write is issued
               if (sel_wr) begin
                  rd_q   <= sel_rd;
                  data_q <= sel_data;
               end
            end
         endcase
      end
   end

   // Saturating count of RUN cycles where both sources compete
   always_comb begin
      cnt_d = cnt_q;
      if (run && s0_valid && s1_valid && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   // Contention counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   always_comb begin
      regwr        = regwr_q;
      rd           = rd_q;
      data         = data_q;
      init_done    = init_done_q;
      conflict_cnt = cnt_q;
   end

endmodule
